// File: rtl/block_ram_be.sv
// Simple dual-port RAM with per-byte write enables, 1/2-cycle registered read,
// selectable read-during-write behaviour and an optional post-reset clear sweep.
module block_ram_be #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned WRITE_FIRST    = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                write_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     byte_en,
    input  logic [DATA_WIDTH-1:0]                data_in,
    input  logic                                 rd_en,
    input  logic [ADDR_WIDTH-1:0]                read_addr,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 data_valid,
    output logic                                 busy
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("block_ram_be: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("block_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   wr_acc;
    logic                   rd_acc;
    logic                   clr_we;
    logic [DATA_WIDTH-1:0]  rd_word;

    logic [DATA_WIDTH-1:0]  s1_data_q;
    logic                   s1_vld_q;

    assign busy   = (state_q == ST_CLEAR);
    assign wr_acc = wr_en && !busy && !rst;
    assign rd_acc = rd_en && !busy && !rst;
    assign clr_we = (state_q == ST_CLEAR) && !rst;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (rst) begin
            state_d    = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_addr_d = '0;
        end else if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        clr_addr_q <= clr_addr_d;
    end

    // Array has no reset; the clear sweep and user writes share the single write port.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr_q] <= '0;
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    mem_q[write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-first bypass: enabled lanes of a same-address write override the stored word.
    always_comb begin
        rd_word = mem_q[read_addr];
        if (WRITE_FIRST != 0 && wr_acc && (write_addr == read_addr)) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_vld_q <= rd_acc;
            if (rd_acc) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_data_q <= '0;
                s2_vld_q  <= 1'b0;
            end else begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign data_out   = s2_data_q;
        assign data_valid = s2_vld_q;
    end else begin : g_lat1
        assign data_out   = s1_data_q;
        assign data_valid = s1_vld_q;
    end

endmodule

// File: tb/tb_block_ram_be.sv
// Scoreboard bench: two RAM instances (latency 1/read-first, latency 2/write-first)
// share one stimulus stream and are checked against a behavioural memory model.
module tb_block_ram_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  write_addr;
    logic [3:0]  byte_en;
    logic [31:0] data_in;
    logic        rd_en;
    logic [3:0]  read_addr;

    logic [31:0] a_dout, b_dout;
    logic        a_vld, b_vld, a_busy, b_busy;

    always #5 clk = ~clk;

    block_ram_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .write_addr(write_addr),
        .byte_en(byte_en), .data_in(data_in), .rd_en(rd_en),
        .read_addr(read_addr), .data_out(a_dout), .data_valid(a_vld), .busy(a_busy)
    );

    block_ram_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .write_addr(write_addr),
        .byte_en(byte_en), .data_in(data_in), .rd_en(rd_en),
        .read_addr(read_addr), .data_out(b_dout), .data_valid(b_vld), .busy(b_busy)
    );

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] m_mem [16];
    logic        m_busy  = 1'b0;
    logic [3:0]  m_clr   = '0;
    logic [31:0] last_a  = '0;
    logic [31:0] last_b  = '0;
    int unsigned cyc     = 0;
    int unsigned cnt_a   = 0;
    int unsigned cnt_b   = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %08h expected %08h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic monitor();
        if (qa.size() > 0 && qa[0].due == cyc) begin
            check_eq("a_valid", {31'b0, a_vld}, 32'd1);
            check_eq("a_data", a_dout, qa[0].data);
            last_a = qa[0].data;
            void'(qa.pop_front());
            cnt_a++;
        end else begin
            check_eq("a_valid_idle", {31'b0, a_vld}, 32'd0);
            check_eq("a_hold", a_dout, last_a);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            check_eq("b_valid", {31'b0, b_vld}, 32'd1);
            check_eq("b_data", b_dout, qb[0].data);
            last_b = qb[0].data;
            void'(qb.pop_front());
            cnt_b++;
        end else begin
            check_eq("b_valid_idle", {31'b0, b_vld}, 32'd0);
            check_eq("b_hold", b_dout, last_b);
        end
        check_eq("a_busy", {31'b0, a_busy}, {31'b0, m_busy});
        check_eq("b_busy", {31'b0, b_busy}, {31'b0, m_busy});
    endtask

    // Model evaluates acceptance on the inputs in front of the coming edge, then advances.
    task automatic step();
        logic        acc_rd, acc_wr;
        logic [31:0] old_w, new_w;
        acc_rd = rd_en && !m_busy && !rst;
        acc_wr = wr_en && !m_busy && !rst;
        if (acc_rd) begin
            old_w = m_mem[read_addr];
            new_w = (acc_wr && write_addr == read_addr) ? merge(old_w, data_in, byte_en) : old_w;
            qa.push_back('{data: old_w, due: cyc + 1});
            qb.push_back('{data: new_w, due: cyc + 2});
        end
        if (rst) begin
            qa.delete();
            qb.delete();
            m_busy = 1'b1;
            m_clr  = '0;
            last_a = '0;
            last_b = '0;
        end else if (m_busy) begin
            m_mem[m_clr] = '0;
            if (m_clr == 4'hF) m_busy = 1'b0;
            m_clr = m_clr + 4'd1;
        end else if (acc_wr) begin
            m_mem[write_addr] = merge(m_mem[write_addr], data_in, byte_en);
        end
        @(posedge clk);
        cyc++;
        #1;
        monitor();
    endtask

    task automatic drive(input logic w, input logic [3:0] wa, input logic [3:0] be,
                         input logic [31:0] d, input logic r, input logic [3:0] ra);
        wr_en = w; write_addr = wa; byte_en = be; data_in = d;
        rd_en = r; read_addr = ra;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Requests during the clear sweep must be dropped.
        drive(1'b1, 4'd2, 4'hF, 32'h55, 1'b1, 4'd2);
        repeat (16) step();
        idle();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2);
        step();
        idle();
        repeat (3) step();

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 4'hF, 32'hDEADBEEF, 1'b0, 4'd0);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (16) step();
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(i));
            step();
        end
        idle();
        repeat (3) step();
        check_eq("a_clear_reads", cnt_a, 32'd16);
        check_eq("b_clear_reads", cnt_b, 32'd16);

        drive(1'b1, 4'd3, 4'hF, 32'h11223344, 1'b0, 4'd0); step();
        drive(1'b1, 4'd3, 4'h5, 32'hAABBCCDD, 1'b0, 4'd0); step();
        drive(1'b1, 4'd3, 4'h0, 32'hFFFFFFFF, 1'b0, 4'd0); step();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd3); step();
        idle();
        repeat (3) step();

        drive(1'b1, 4'd0, 4'hF, 32'hA, 1'b0, 4'd0); step();
        drive(1'b1, 4'd1, 4'hF, 32'hB, 1'b0, 4'd0); step();
        drive(1'b1, 4'd2, 4'hF, 32'hC, 1'b0, 4'd0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(i));
            step();
        end
        idle();
        repeat (4) step();

        drive(1'b1, 4'd5, 4'b0011, 32'hFFFFFFFF, 1'b1, 4'd5); step();
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd5); step();
        idle();
        repeat (3) step();

        // Reset one cycle after an accepted read, then again part-way through the sweep.
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd1); step();
        idle();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (5) step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (16) step();
        step();

        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom),
                  $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
            rst = ($urandom_range(0, 99) == 0);
            step();
            rst = 1'b0;
        end
        idle();
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/block_ram_be.md
# block_ram_be

Parametrised simple dual-port block RAM: one write port with per-byte enables, one read port with a configurable 1- or 2-cycle read pipeline and a read-valid strobe. Same-address read/write collisions follow a parameter-selected read-during-write mode. An optional reset-time clear engine zeroes the whole array. It is the general-purpose storage primitive behind FIFOs, line buffers and lookup tables in the datapath.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1, 1 or 2 cycles from accepted read to data_out; other values are a elaboration error.
- WRITE_FIRST, 0, 0 = same-cycle collision returns old data; 1 = returns newly written data.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents untouched by reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- write_addr  input  ADDR_WIDTH  write address.
- byte_en  input  NB  lane i writes data_in[i*BYTE_WIDTH +: BYTE_WIDTH].
- data_in  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- read_addr  input  ADDR_WIDTH  read address.
- data_out  output  DATA_WIDTH  read data, registered.
- data_valid  output  1  one-cycle pulse per accepted read, aligned with data_out.
- busy  output  1  clear engine active; requests ignored.

## Operation
- Clear FSM states: CLEAR, IDLE. rst high: state <= CLEAR (or IDLE if CLEAR_ON_RESET=0), clr_addr <= 0, no array write.
- CLEAR (rst low): write all-zero word to clr_addr, clr_addr++ each cycle; after writing address 2**ADDR_WIDTH-1, state <= IDLE. Clear takes exactly 2**ADDR_WIDTH cycles after rst deasserts.
- busy = (state == CLEAR), registered with state.
- Write accepted when wr_en && !busy && !rst: only lanes with byte_en set are updated; byte_en all-zero is a no-op.
- Read accepted when rd_en && !busy && !rst.
- Collision (accepted read and write, same address, same cycle): WRITE_FIRST=0 -> old word; WRITE_FIRST=1 -> enabled lanes from data_in, other lanes from old word.
- Read one cycle after a write to the same address always returns the updated word.
- No accepted read: data_out holds its last value; data_valid 0.
- Reset values: data_out = 0, data_valid = 0, busy = CLEAR_ON_RESET, all pipeline stages and valid bits cleared.

## Timing
- Write: array updated at the edge where accepted.
- READ_LATENCY=1: read accepted at edge N -> data_out/data_valid valid after edge N+1.
- READ_LATENCY=2: extra output register; valid after edge N+2. Back-to-back reads give one result per cycle, in order.
- rst asserted mid-operation: in-flight reads discarded (data_valid never pulses for them); clear restarts from address 0.
- Requests presented while busy are dropped, not queued.
- busy falls at the edge after the last clear write; first accept possible in that same cycle.

## Test plan
- Reset/clear: ADDR_WIDTH=4, CLEAR_ON_RESET=1, pre-load 0xDEADBEEF everywhere, pulse rst 1 cycle -> busy high for 16 cycles; then reading addresses 0..15 returns 0x00000000 each, data_valid pulses 16 times.
- Byte enables: write 0x11223344 to addr 3 with byte_en=4'b1111, then 0xAABBCCDD with byte_en=4'b0101 -> read addr 3 returns 0x11BB33DD.
- Latency: READ_LATENCY=2, reads of addr 0,1,2 in consecutive cycles holding 0xA,0xB,0xC -> data_valid high on cycles N+2..N+4 with data 0xA,0xB,0xC; data_out holds 0xC afterwards.
- Collision: addr 5 holds 0x00000000; same-cycle write 0xFFFFFFFF (byte_en=4'b0011) and read of addr 5 -> WRITE_FIRST=0 returns 0x00000000, WRITE_FIRST=1 returns 0x0000FFFF; read next cycle returns 0x0000FFFF in both modes.
- Busy gating: during clear drive wr_en to addr 2 with 0x55 and rd_en -> no data_valid pulse; after clear, addr 2 reads 0.
- Reset mid-read: READ_LATENCY=2, accept read, assert rst next cycle -> data_valid stays 0, data_out = 0, clear restarts at address 0.
